// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: pointer width helper
// and the packed status word exposed to peripheral register maps.
package fifo_pkg;

    // Pointers carry one extra wrap bit above the RAM address bits
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_sync_ram.sv
// DEPTH x DATA_WIDTH storage for the synchronous FIFO: registered write,
// combinational read so the head entry is visible without a read cycle.
module fifo_sync_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; only pointers define validity
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous show-ahead FIFO with occupancy count, almost flags,
// flush, and optional sticky overflow/underflow flags (macro FIFO_ERR_EN).
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          wr_en,
    output logic                          full,
    output logic                          almost_full,
    output logic [DATA_WIDTH-1:0]         rdata,
    input  logic                          rd_en,
    output logic                          empty,
    output logic                          almost_empty,
    output logic [ptr_width(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          err_clr
);

    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int ADDR_W = PTR_W - 1;

    localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             wr_ok, rd_ok;
    fifo_status_t     status;

    // Status comes from registered pointers only, never from wr_en/rd_en
    assign count               = wr_ptr_q - rd_ptr_q;
    assign status.full         = (count == DEPTH_C);
    assign status.almost_full  = (count >= AFULL_C);
    assign status.empty        = (count == '0);
    assign status.almost_empty = (count <= AEMPTY_C);

    assign full         = status.full;
    assign almost_full  = status.almost_full;
    assign empty        = status.empty;
    assign almost_empty = status.almost_empty;

    // A read on a full FIFO frees the slot the concurrent write lands in
    assign wr_ok = wr_en & (~status.full | rd_en);
    assign rd_ok = rd_en & ~status.empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_sync_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok & ~clr),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (rdata)
    );

`ifdef FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error outranks a coincident err_clr
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en & status.full & ~rd_en) overflow_d  = 1'b1;
        if (rd_en & status.empty)         underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule
